pixel_mem_arbiter: RTL and testbench

Arbitrates one single-port RGB565 pixel memory between two requesters: the HDMI display read path, which feeds PIXEL to the RGB video pattern generator, and the camera write path, which stores captured pixels. The display read has priority so that active video is not starved. A starvation counter forces a write slot periodically, so camera writes still make progress. Memory commands are registered, and read data returns in order with a fixed latency.

---
 rtl/pixel_mem_pkg.sv | 36 +++
 rtl/pixel_rd_return.sv | 59 +++++
 rtl/pixel_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_pixel_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_mem_pkg.sv
// ============================================================================
// Module      : pixel_mem_pkg
// Description : Shared types and defaults for the pixel memory arbiter.
//               Holds the arbiter state enum, the default address and data
//               widths, the RGB565 pixel type and a saturating helper.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pixel_mem_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 16;
  localparam int STAT_W     = 16;

  // Arbiter states: read priority (reset state) and one forced write slot
  typedef enum logic [0:0] {
    RD_PRIO  = 1'b0,
    WR_FORCE = 1'b1
  } arb_state_e;

  // RGB565 pixel as stored in the frame memory
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_rd_return.sv
// ============================================================================
// Module      : pixel_rd_return
// Description : Read return path. A RD_LAT-deep valid shift register tracks
//               granted reads; when a token leaves the pipe the memory read
//               data is captured, so returns stay in grant order.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_rd_return #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;

  // Shift a token in for every read grant; depth 1 needs no concatenation
  generate
    if (RD_LAT == 1) begin : g_lat_one
      always_comb vld_pipe_d = issue;
    end else begin : g_lat_multi
      always_comb vld_pipe_d = {vld_pipe_q[RD_LAT-2:0], issue};
    end
  endgenerate

  // Capture memory data in the cycle the oldest token reaches the pipe end
  always_comb begin
    rd_valid_d = vld_pipe_q[RD_LAT-1];
    rd_data_d  = vld_pipe_q[RD_LAT-1] ? mem_rdata : rd_data_q;
  end

  // Pipeline and capture registers; reset discards returns in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/pixel_mem_arbiter.sv
// ============================================================================
// Module      : pixel_mem_arbiter
// Description : Single-port RGB565 pixel memory arbiter. Display reads have
//               priority; a starvation counter forces one camera write slot
//               after WR_MAX_WAIT consecutive lost cycles. Commands are
//               registered; reads return in order after RD_LAT+1 cycles.
//               Optional macro ARB_STATS_EN adds saturating stall counters.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_mem_arbiter
  import pixel_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RD_LAT      = 2,
  parameter int WR_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] rd_stall_cnt,
  output logic [STAT_W-1:0] wr_stall_cnt
`endif
);

  localparam logic [7:0] MAX_WAIT = WR_MAX_WAIT[7:0];

  arb_state_e        state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RD_PRIO;
    else       state_q <= state_d;
  end

  // Grant decode: reads win normally, the forced slot belongs to the write
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    case (state_q)
      RD_PRIO: begin
        rd_gnt = rd_req;
        wr_gnt = wr_req & ~rd_req;
      end
      WR_FORCE: wr_gnt = wr_req;
      default: ;
    endcase
  end

  // Starvation counter: counts consecutive cycles a pending write loses
  always_comb begin
    if ((state_q == WR_FORCE) || wr_gnt || !wr_req) wait_cnt_d = '0;
    else                                            wait_cnt_d = wait_cnt_q + 8'd1;
  end

  // Next state: enter the forced slot as soon as the loss count hits the limit
  always_comb begin
    state_d = RD_PRIO;
    case (state_q)
      RD_PRIO:  if (wait_cnt_d == MAX_WAIT) state_d = WR_FORCE;
      WR_FORCE: state_d = RD_PRIO;
      default:  state_d = RD_PRIO;
    endcase
  end

  // Command register contents taken from the winner; idle cycles drop mem_en
  always_comb begin
    mem_en_d    = rd_gnt | wr_gnt;
    mem_we_d    = wr_gnt;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (wr_gnt) begin
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
    end else if (rd_gnt) begin
      mem_addr_d  = rd_addr;
    end
  end

  // Starvation counter and memory command registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  pixel_rd_return #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_return (
    .clk       (clk),
    .reset     (reset),
    .issue     (rd_gnt),
    .mem_rdata (mem_rdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] rd_stall_q, rd_stall_d;
  logic [STAT_W-1:0] wr_stall_q, wr_stall_d;

  // Stall statistics: requested but not granted, saturating at all-ones
  always_comb begin
    rd_stall_d = (rd_req && !rd_gnt) ? sat_inc(rd_stall_q) : rd_stall_q;
    wr_stall_d = (wr_req && !wr_gnt) ? sat_inc(wr_stall_q) : wr_stall_q;
  end

  // Stall counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else begin
      rd_stall_q <= rd_stall_d;
      wr_stall_q <= wr_stall_d;
    end
  end

  assign rd_stall_cnt = rd_stall_q;
  assign wr_stall_cnt = wr_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_mem_arbiter.sv
// ============================================================================
// Module      : tb_pixel_mem_arbiter
// Description : Self-checking bench for pixel_mem_arbiter with a behavioural
//               arbitration/memory reference model and randomized traffic.
//               Stat-counter checks are active when ARB_STATS_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pixel_mem_arbiter;

  localparam int AW          = 17;
  localparam int DW          = 16;
  localparam int RD_LAT      = 2;
  localparam int WR_MAX_WAIT = 8;
  localparam int MSZ         = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_gnt, wr_gnt, rd_valid, mem_en, mem_we;
  logic [DW-1:0] rd_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
`ifdef ARB_STATS_EN
  logic [15:0]   rd_stall_cnt, wr_stall_cnt;
`endif

  always #5 clk = ~clk;

  pixel_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .WR_MAX_WAIT(WR_MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .rd_stall_cnt(rd_stall_cnt), .wr_stall_cnt(wr_stall_cnt)
`endif
  );

  // Memory behind the arbiter: data appears the cycle after the mem_en cycle,
  // which is RD_LAT-1 cycles for the RD_LAT=2 used here. Unwritten locations
  // read as address + 0x100.
  logic [DW-1:0] env_mem [MSZ];
  bit            env_wr  [MSZ];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      env_mem[mem_addr[7:0]] <= mem_wdata;
      env_wr[mem_addr[7:0]]  <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]]
                                         : {8'h00, mem_addr[7:0]} + 16'h0100;
    else
      mem_rdata <= 16'hDEAD;
  end

  // ---------------- reference model ----------------
  typedef struct { int due; logic [DW-1:0] d; } ret_t;
  ret_t          ret_q[$];
  logic [DW-1:0] shadow[int];
  int            cyc, losses;
  bit            force_nx;
  bit            e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int            e_rs, e_ws;
  bit            g_rd, g_wr;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : DW'(a) + 16'h0100;
  endfunction

  task automatic model_reset();
    cyc = 0; losses = 0; force_nx = 0;
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    ret_q.delete();
    e_rs = 0; e_ws = 0;
  endtask

  // One clock cycle: enter at posedge+1, drive, check at negedge, advance model
  task automatic step(input bit rq, input int ra, input bit wq, input int wa,
                      input logic [DW-1:0] wd);
    bit xr, xw, xv;
    rd_req = rq; rd_addr = AW'(ra);
    wr_req = wq; wr_addr = AW'(wa); wr_data = wd;
    #4;
    if (force_nx) begin xr = 1'b0; xw = wq; end
    else          begin xr = rq;   xw = wq & ~rq; end
    chk("rd_gnt", rd_gnt, xr);
    chk("wr_gnt", wr_gnt, xw);
    chk("mem_en", mem_en, e_en);
    if (e_en) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
    xv = (ret_q.size() > 0) && (ret_q[0].due == cyc);
    chk("rd_valid", rd_valid, xv);
    if (xv) begin
      chk("rd_data", rd_data, ret_q[0].d);
      void'(ret_q.pop_front());
    end
`ifdef ARB_STATS_EN
    chk("rd_stall_cnt", rd_stall_cnt, e_rs);
    chk("wr_stall_cnt", wr_stall_cnt, e_ws);
`endif
    g_rd = rd_gnt; g_wr = wr_gnt;
    // model advance
    e_en = xr | xw;
    e_we = xw;
    if (xw) begin
      e_addr = AW'(wa); e_wdata = wd; shadow[wa] = wd;
    end else if (xr) begin
      e_addr = AW'(ra);
    end
    if (xr) ret_q.push_back('{cyc + 1 + RD_LAT, shadow_rd(ra)});
    if (rq && !xr && e_rs < 65535) e_rs++;
    if (wq && !xw && e_ws < 65535) e_ws++;
    if (force_nx) begin
      force_nx = 0; losses = 0;
    end else begin
      if (wq && !xw) losses++;
      else           losses = 0;
      force_nx = (losses == WR_MAX_WAIT);
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  // Assert reset asynchronously, check reset values, release two edges later
  task automatic do_reset();
    reset = 1'b1; rd_req = 0; wr_req = 0;
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
`ifdef ARB_STATS_EN
    chk("rst_rd_stall", rd_stall_cnt, 0);
    chk("rst_wr_stall", wr_stall_cnt, 0);
`endif
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [39:0] wmask, wexp;
    int          n;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Read only: ten reads of addresses 0..9, data 0x100..0x109 in order
    for (int i = 0; i < 10; i++) step(1, i, 0, 0, '0);
    for (int i = 0; i < 5; i++)  step(0, 0, 0, 0, '0);

    // Write only: granted at once, command visible the next cycle
    step(0, 0, 1, 5, 16'hF800);
    chk("wo_gnt", g_wr, 1);
    chk("wo_mem_en", mem_en, 1);
    chk("wo_mem_we", mem_we, 1);
    chk("wo_mem_addr", mem_addr, 5);
    chk("wo_mem_wdata", mem_wdata, 16'hF800);
    step(1, 5, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0);

    // Contention: writes on the 9th, 18th, 27th and 36th cycle
    do_reset();
    wmask = '0;
    for (int i = 0; i < 40; i++) begin
      step(1, $urandom_range(0, 63), 1, $urandom_range(64, 127), 16'($urandom));
      wmask[i] = g_wr;
    end
    wexp = '0;
    wexp[8] = 1'b1; wexp[17] = 1'b1; wexp[26] = 1'b1; wexp[35] = 1'b1;
    chk("contention_wr_slots", wmask[31:0], wexp[31:0]);
    chk("contention_wr_slots_hi", {24'h0, wmask[39:32]}, {24'h0, wexp[39:32]});
`ifdef ARB_STATS_EN
    chk("contention_wr_stall", wr_stall_cnt, 36);
    chk("contention_rd_stall", rd_stall_cnt, 4);
`endif
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0);

    // Force cancelled: write request withdrawn in the forced cycle
    n = 0;
    while (!force_nx && n < 40) begin
      step(1, $urandom_range(0, 63), 1, $urandom_range(64, 127), 16'($urandom));
      n++;
    end
    chk("force_reached", force_nx, 1);
    step(1, 7, 0, 0, '0);
    chk("cancel_rd_gnt", g_rd, 0);
    chk("cancel_wr_gnt", g_wr, 0);
    chk("cancel_mem_en", mem_en, 0);
    step(1, 8, 0, 0, '0);
    chk("cancel_rd_resume", g_rd, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, $urandom_range(0, 63),
           $urandom % 2, $urandom_range(0, 63), 16'($urandom));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, '0);

    // Reset mid-flight after three read grants
    for (int i = 0; i < 3; i++) step(1, 20 + i, 0, 0, '0);
    chk("pre_reset_valid", rd_valid, 1);
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, '0);

`ifdef ARB_STATS_EN
    // Saturation: long contention drives the write stall count to its limit
    for (int i = 0; i < 74000; i++) step(1, i % 64, 1, 64 + (i % 64), 16'(i));
    chk("sat_wr_stall", wr_stall_cnt, 16'hFFFF);
    for (int i = 0; i < 20; i++) step(1, i, 1, 64 + i, 16'(i));
    chk("sat_wr_stall_hold", wr_stall_cnt, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
